// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and counter sizing.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Wait counter holds up to WAIT_CYCLES-1 (max 14).
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: fixed highest-index or rotating priority after last_grant_i.
module mem_arb_pick #(
    parameter int unsigned CLIENT_CNT = 4,
    parameter int unsigned IDX_W      = $clog2(CLIENT_CNT)
) (
    input  logic [CLIENT_CNT-1:0] requests_i,
    input  logic [IDX_W-1:0]      last_grant_i,
    input  logic                  rr_mode_i,
    output logic [IDX_W-1:0]      winner_o,
    output logic                  valid_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        winner_o = '0;
        valid_o  = |requests_i;
        idx      = 0;
        found    = 1'b0;
        if (rr_mode_i) begin
            // First active request at or after last_grant_i+1, wrapping.
            for (int unsigned k = 0; k < CLIENT_CNT; k++) begin
                idx = (32'(last_grant_i) + k + 32'd1) % CLIENT_CNT;
                if (!found && requests_i[IDX_W'(idx)]) begin
                    winner_o = IDX_W'(idx);
                    found    = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < CLIENT_CNT; i++) begin
                if (requests_i[IDX_W'(i)]) begin
                    winner_o = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates single-port memory access among CLIENT_CNT clients with fixed latency
// and a ready/request handshake per client.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned CLIENT_CNT  = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CLIENT_CNT-1:0]          requests,
    input  logic [CLIENT_CNT*ADDR_W-1:0]   addrs,
    input  logic [CLIENT_CNT-1:0]          wes,
    input  logic [CLIENT_CNT*DATA_W-1:0]   data_outs,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic [CLIENT_CNT-1:0]          readies,
    output logic [DATA_W-1:0]              rdata,
    output logic [ADDR_W-1:0]              addr,
    output logic [DATA_W-1:0]              data_out,
    output logic                           we,
    output logic [$clog2(CLIENT_CNT)-1:0]  grant,
    output logic                           busy
);

    localparam int unsigned IDX_W = $clog2(CLIENT_CNT);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [CLIENT_CNT-1:0] readies_q, readies_d;
    logic                  busy_q, busy_d;
    logic                  fresh_q, fresh_d;

    logic [IDX_W-1:0]      win;
    logic                  win_vld;
    logic [IDX_W-1:0]      search_base;

    // Until the first grant after reset, pretend the last holder was the top index so the search starts at 0.
    assign search_base = fresh_q ? IDX_W'(CLIENT_CNT - 1) : grant_q;

    mem_arb_pick #(
        .CLIENT_CNT (CLIENT_CNT),
        .IDX_W      (IDX_W)
    ) u_pick (
        .requests_i   (requests),
        .last_grant_i (search_base),
        .rr_mode_i    (ROUND_ROBIN != 0),
        .winner_o     (win),
        .valid_o      (win_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            grant_q   <= '0;
            readies_q <= '0;
            busy_q    <= 1'b0;
            fresh_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            we_q      <= we_d;
            grant_q   <= grant_d;
            readies_q <= readies_d;
            busy_q    <= busy_d;
            fresh_q   <= fresh_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        we_d      = 1'b0;
        grant_d   = grant_q;
        readies_d = readies_q;
        fresh_d   = fresh_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    addr_d  = addrs[32'(win) * ADDR_W +: ADDR_W];
                    data_d  = data_outs[32'(win) * DATA_W +: DATA_W];
                    we_d    = wes[win];
                    grant_d = win;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    fresh_d = 1'b0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    rdata_d            = mem_rdata;
                    readies_d          = '0;
                    readies_d[grant_q] = 1'b1;
                    state_d            = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (!requests[grant_q]) begin
                    readies_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign readies  = readies_q;
    assign rdata    = rdata_q;
    assign addr     = addr_q;
    assign data_out = data_q;
    assign we       = we_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: four instances share stimulus (RR/WC1, fixed/WC1, RR/WC4, RR/WC3).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  requests = '0;
    logic [31:0] addrs = '0;
    logic [3:0]  wes = '0;
    logic [31:0] data_outs = '0;
    logic [7:0]  mem_rdata = '0;

    logic [3:0] readies_a, readies_f, readies_l, readies_r;
    logic [7:0] rdata_a, rdata_f, rdata_l, rdata_r;
    logic [7:0] addr_a, addr_f, addr_l, addr_r;
    logic [7:0] data_out_a, data_out_f, data_out_l, data_out_r;
    logic       we_a, we_f, we_l, we_r;
    logic [1:0] grant_a, grant_f, grant_l, grant_r;
    logic       busy_a, busy_f, busy_l, busy_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.CLIENT_CNT(4), .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1), .ROUND_ROBIN(1)) dut_a (
        .clk(clk), .rst(rst), .requests(requests), .addrs(addrs), .wes(wes),
        .data_outs(data_outs), .mem_rdata(mem_rdata), .readies(readies_a), .rdata(rdata_a),
        .addr(addr_a), .data_out(data_out_a), .we(we_a), .grant(grant_a), .busy(busy_a));

    mem_arbiter #(.CLIENT_CNT(4), .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1), .ROUND_ROBIN(0)) dut_f (
        .clk(clk), .rst(rst), .requests(requests), .addrs(addrs), .wes(wes),
        .data_outs(data_outs), .mem_rdata(mem_rdata), .readies(readies_f), .rdata(rdata_f),
        .addr(addr_f), .data_out(data_out_f), .we(we_f), .grant(grant_f), .busy(busy_f));

    mem_arbiter #(.CLIENT_CNT(4), .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(4), .ROUND_ROBIN(1)) dut_l (
        .clk(clk), .rst(rst), .requests(requests), .addrs(addrs), .wes(wes),
        .data_outs(data_outs), .mem_rdata(mem_rdata), .readies(readies_l), .rdata(rdata_l),
        .addr(addr_l), .data_out(data_out_l), .we(we_l), .grant(grant_l), .busy(busy_l));

    mem_arbiter #(.CLIENT_CNT(4), .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(3), .ROUND_ROBIN(1)) dut_r (
        .clk(clk), .rst(rst), .requests(requests), .addrs(addrs), .wes(wes),
        .data_outs(data_outs), .mem_rdata(mem_rdata), .readies(readies_r), .rdata(rdata_r),
        .addr(addr_r), .data_out(data_out_r), .we(we_r), .grant(grant_r), .busy(busy_r));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        requests = '0;
        wes      = '0;
        rst      = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({readies_a, rdata_a, addr_a, data_out_a, we_a, grant_a, busy_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected 0",
                     {readies_a, rdata_a, addr_a, data_out_a, we_a, grant_a, busy_a});
        end
        n_checks++;
        if ({readies_l, rdata_l, addr_l, data_out_l, we_l, grant_l, busy_l} !== '0) begin
            n_fail++;
            $display("FAIL reset_l: got %h expected 0",
                     {readies_l, rdata_l, addr_l, data_out_l, we_l, grant_l, busy_l});
        end
    endtask

    task automatic test_single_read();
        do_reset();
        addrs[2*8 +: 8] = 8'h3C;
        mem_rdata       = 8'hA5;
        requests        = 4'b0100;
        tick();
        n_checks++;
        if (addr_a !== 8'h3C || grant_a !== 2'd2 || busy_a !== 1'b1 || readies_a !== 4'b0000 || we_a !== 1'b0) begin
            n_fail++;
            $display("FAIL read_grant: addr=%h grant=%0d busy=%b readies=%b we=%b expected addr=3c grant=2 busy=1 readies=0000 we=0",
                     addr_a, grant_a, busy_a, readies_a, we_a);
        end
        tick();
        n_checks++;
        if (readies_a !== 4'b0100 || rdata_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_ready: readies=%b rdata=%h expected 0100 a5", readies_a, rdata_a);
        end
        tick();
        n_checks++;
        if (readies_a !== 4'b0100 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL read_hold: readies=%b busy=%b expected 0100 1", readies_a, busy_a);
        end
        requests = 4'b0000;
        tick();
        n_checks++;
        if (readies_a !== 4'b0000 || busy_a !== 1'b0 || addr_a !== 8'h3C) begin
            n_fail++;
            $display("FAIL read_release: readies=%b busy=%b addr=%h expected 0000 0 3c", readies_a, busy_a, addr_a);
        end
    endtask

    task automatic test_write();
        // Continues from idle after the read; last grant was 2, so client 1 wins via wrap-around.
        addrs[1*8 +: 8]     = 8'h10;
        data_outs[1*8 +: 8] = 8'h5A;
        wes                 = 4'b0010;
        requests            = 4'b0010;
        tick();
        n_checks++;
        if (we_a !== 1'b1 || addr_a !== 8'h10 || data_out_a !== 8'h5A || grant_a !== 2'd1) begin
            n_fail++;
            $display("FAIL write_grant: we=%b addr=%h data_out=%h grant=%0d expected 1 10 5a 1",
                     we_a, addr_a, data_out_a, grant_a);
        end
        requests = 4'b0000;
        tick();
        n_checks++;
        if (we_a !== 1'b0 || readies_a !== 4'b0010) begin
            n_fail++;
            $display("FAIL write_ready: we=%b readies=%b expected 0 0010", we_a, readies_a);
        end
        tick();
        n_checks++;
        if (readies_a !== 4'b0000 || busy_a !== 1'b0 || data_out_a !== 8'h5A || we_a !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done: readies=%b busy=%b data_out=%h we=%b expected 0000 0 5a 0",
                     readies_a, busy_a, data_out_a, we_a);
        end
        wes = 4'b0000;
    endtask

    task automatic test_fixed();
        int exp_g[3] = '{3, 3, 3};
        int n;
        do_reset();
        requests = 4'b1011;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (readies_f === 4'b0000 && n < 20) begin
                tick();
                n++;
            end
            n_checks++;
            if (readies_f === 4'b0000 || 32'(grant_f) != exp_g[r] || $countones(readies_f) != 1) begin
                n_fail++;
                $display("FAIL fixed_round%0d: grant=%0d readies=%b expected grant=%0d one-hot", r, grant_f, readies_f, exp_g[r]);
            end
            requests[grant_f] = 1'b0;
            tick();
            requests = 4'b1011;
        end
        requests = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        int exp_g[5] = '{0, 1, 3, 0, 1};
        int n;
        do_reset();
        requests = 4'b1011;
        for (int r = 0; r < 5; r++) begin
            n = 0;
            while (readies_a === 4'b0000 && n < 20) begin
                tick();
                n++;
            end
            n_checks++;
            if (readies_a === 4'b0000 || 32'(grant_a) != exp_g[r] || readies_a !== (4'b0001 << exp_g[r])) begin
                n_fail++;
                $display("FAIL rr_round%0d: grant=%0d readies=%b expected grant=%0d", r, grant_a, readies_a, exp_g[r]);
            end
            requests[grant_a] = 1'b0;
            tick();
            requests = 4'b1011;
        end
        requests = 4'b0000;
        tick();
    endtask

    task automatic test_latency();
        int  n;
        logic busy_ok;
        do_reset();
        addrs[0 +: 8] = 8'h77;
        mem_rdata     = 8'h3E;
        requests      = 4'b0001;
        tick();
        n_checks++;
        if (busy_l !== 1'b1 || addr_l !== 8'h77 || readies_l !== 4'b0000) begin
            n_fail++;
            $display("FAIL lat_grant: busy=%b addr=%h readies=%b expected 1 77 0000", busy_l, addr_l, readies_l);
        end
        n       = 0;
        busy_ok = 1'b1;
        while (readies_l === 4'b0000 && n < 10) begin
            tick();
            n++;
            if (busy_l !== 1'b1) busy_ok = 1'b0;
        end
        n_checks++;
        if (n != 4 || busy_ok !== 1'b1 || readies_l !== 4'b0001 || rdata_l !== 8'h3E) begin
            n_fail++;
            $display("FAIL lat_ready: edges=%0d busy_ok=%b readies=%b rdata=%h expected 4 1 0001 3e",
                     n, busy_ok, readies_l, rdata_l);
        end
        requests = 4'b0000;
        tick();
        n_checks++;
        if (busy_l !== 1'b0 || readies_l !== 4'b0000) begin
            n_fail++;
            $display("FAIL lat_exit: busy=%b readies=%b expected 0 0000", busy_l, readies_l);
        end
    endtask

    task automatic test_reset_mid_access();
        int n;
        do_reset();
        addrs[2*8 +: 8]     = 8'h3C;
        data_outs[2*8 +: 8] = 8'hC3;
        mem_rdata           = 8'h99;
        requests            = 4'b0100;
        tick();
        n_checks++;
        if (busy_r !== 1'b1 || addr_r !== 8'h3C || grant_r !== 2'd2) begin
            n_fail++;
            $display("FAIL rst_mid_grant: busy=%b addr=%h grant=%0d expected 1 3c 2", busy_r, addr_r, grant_r);
        end
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({readies_r, rdata_r, addr_r, data_out_r, we_r, grant_r, busy_r} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got %h expected 0",
                     {readies_r, rdata_r, addr_r, data_out_r, we_r, grant_r, busy_r});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        n_checks++;
        if (readies_r !== 4'b0000 || busy_r !== 1'b1 || grant_r !== 2'd2 || addr_r !== 8'h3C) begin
            n_fail++;
            $display("FAIL rst_mid_regrant: readies=%b busy=%b grant=%0d addr=%h expected 0000 1 2 3c",
                     readies_r, busy_r, grant_r, addr_r);
        end
        n = 0;
        while (readies_r === 4'b0000 && n < 10) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 3 || readies_r !== 4'b0100 || rdata_r !== 8'h99) begin
            n_fail++;
            $display("FAIL rst_mid_ready: edges=%0d readies=%b rdata=%h expected 3 0100 99", n, readies_r, rdata_r);
        end
        requests = 4'b0000;
        tick();
    endtask

    initial begin
        #3;
        test_reset();
        test_single_read();
        test_write();
        test_fixed();
        test_round_robin();
        test_latency();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter CLIENT_CNT, default 4, meaning number of requesting clients (2..16).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning memory address width.
REQ-003 SHALL have parameter DATA_W, default 8, meaning memory data width.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, meaning memory access latency in clocks (1..15).
REQ-005 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = rotating priority and 0 = fixed priority with highest index winning.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-008 SHALL have port requests, input, CLIENT_CNT bits, per-client access request, level, held until ready seen.
REQ-009 SHALL have port addrs, input, CLIENT_CNT*ADDR_W bits, packed client addresses, client i at [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port wes, input, CLIENT_CNT bits, per-client write enable (1 = write).
REQ-011 SHALL have port data_outs, input, CLIENT_CNT*DATA_W bits, packed client write data.
REQ-012 SHALL have port mem_rdata, input, DATA_W bits, read data from memory.
REQ-013 SHALL have port readies, output, CLIENT_CNT bits, per-client completion flag.
REQ-014 SHALL have port rdata, output, DATA_W bits, read data returned to the granted client.
REQ-015 SHALL have port addr, output, ADDR_W bits, memory address.
REQ-016 SHALL have port data_out, output, DATA_W bits, memory write data.
REQ-017 SHALL have port we, output, 1 bit, memory write strobe.
REQ-018 SHALL have port grant, output, $clog2(CLIENT_CNT) bits, index of the current or last holder.
REQ-019 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-020 SHALL implement states IDLE, ACCESS, DONE, all registered.
REQ-021 IDLE: when any request is high at edge G, SHALL select a winner, latch addr, data_out, we and grant from that client, load the wait counter with WAIT_CYCLES-1, and go to ACCESS.
REQ-022 IDLE with no request SHALL hold addr, data_out and grant, and drive we=0.
REQ-023 Fixed mode SHALL pick the highest-indexed active request.
REQ-024 Round-robin mode SHALL search from grant+1 upward with wrap-around modulo CLIENT_CNT; the first active request wins; after reset the search starts at index 0.
REQ-025 we SHALL be high for exactly one clock (edge G to G+1) on writes, then 0.
REQ-026 ACCESS SHALL decrement the counter each clock; at the edge where the counter is 0 (edge G+WAIT_CYCLES) it SHALL capture mem_rdata into rdata, set readies[grant]=1, and go to DONE.
REQ-027 addr and data_out SHALL remain stable from edge G until the next grant.
REQ-028 On writes, rdata SHALL still be captured; its value is don't-care for clients.
REQ-029 DONE: when requests[grant]=0, SHALL clear readies to all-zero and go to IDLE; otherwise hold.
REQ-030 At most one bit of readies SHALL be high at any time.
REQ-031 A request dropped during ACCESS SHALL NOT abort the access; ready asserts for one clock, then DONE exits on the next edge.
REQ-032 Requests from other clients during ACCESS or DONE SHALL be ignored until IDLE; there is no back-to-back grant from DONE, so the minimum inter-grant gap is WAIT_CYCLES+2 clocks.

Reset
REQ-033 Asserting rst SHALL immediately clear: state=IDLE, readies=0, we=0, addr=0, data_out=0, rdata=0, grant=0, counter=0, busy=0; this applies mid-ACCESS too, with the in-flight access abandoned.
REQ-034 After deassertion, the first grant SHALL occur no earlier than the first rising edge with rst low.

Structure
REQ-035 State encoding and the localparams IDLE, ACCESS and DONE SHALL live in shared package mem_pkg.
REQ-036 Winner selection SHALL be a combinational sub-module mem_arb_pick (inputs: requests, last grant, mode; outputs: winner index and valid).

Verification
REQ-037 Single read: CLIENT_CNT=4, WAIT_CYCLES=1, client 2 reads addr 0x3C with mem_rdata=0xA5 -> addr=0x3C after G, readies=4'b0100 and rdata=0xA5 after G+1, readies=0 one edge after requests[2] drops.
REQ-038 Write: client 1 writes 0x5A to 0x10 -> we high exactly one clock, data_out=0x5A, readies[1] at G+1.
REQ-039 Fixed mode: requests=4'b1011 held -> grant sequence 3,3,3 (highest index always wins).
REQ-040 Round-robin: requests=4'b1011 held, each client dropping and re-raising its request after ready -> grant sequence 0,1,3,0,1.
REQ-041 Latency: WAIT_CYCLES=4 -> readies asserted exactly 4 edges after grant; busy high from G until DONE exits.
REQ-042 Reset mid-ACCESS: rst pulsed at G+1 with WAIT_CYCLES=3 -> all outputs zero immediately, no ready pulse, and a new grant follows normally after release.
